lsu_arbiter: RTL and testbench

Two-port arbiter that shares the single LSU data port between the core's load/store path (port 0) and a secondary master such as a boot loader or debug/DMA engine (port 1). Each cycle it grants at most one requester, muxes that requester's address, write data, write enable and funct3 onto the LSU, and returns registered load data to the winner one cycle later. It sits between the datapath/controller and `LSU`. A losing core request is stalled by holding `i_req_0` while `o_gnt_0` is low.

---
 rtl/lsu_arb_pkg.sv | 21 ++
 rtl/lsu_arb_pick.sv | 45 ++++
 rtl/lsu_arbiter.sv | 140 ++++++++++++++
 tb/tb_lsu_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_arb_pkg.sv
// Shared types for the two-port LSU arbiter.
// Consumers honour the LSU_ARB_RR_EN build macro (round-robin vs fixed priority).
package lsu_arb_pkg;

  localparam int DATA_W         = 32;
  localparam int LSU_ARB_NPORTS = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } owner_e;

  typedef struct packed {
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              wren;
    logic [2:0]        funct3;
  } lsu_req_t;

endpackage

// File: rtl/lsu_arb_pick.sv
// Combinational winner selector returning a one-hot grant.
// LSU_ARB_RR_EN selects round-robin with a burst cap; otherwise port 0 has fixed priority.
module lsu_arb_pick
  import lsu_arb_pkg::*;
`ifdef LSU_ARB_RR_EN
#(
  parameter int MAX_BURST = 4,
  parameter int BURST_W   = $clog2(MAX_BURST + 1)
)
`endif
(
  input  logic [LSU_ARB_NPORTS-1:0] req,
  input  owner_e                    owner_q,
`ifdef LSU_ARB_RR_EN
  input  logic [BURST_W-1:0]        burst_q,
  input  logic                      last_q,
`endif
  output logic [LSU_ARB_NPORTS-1:0] gnt
);

`ifdef LSU_ARB_RR_EN
  localparam logic [BURST_W-1:0] BURST_CAP = BURST_W'(MAX_BURST);

  // The current owner keeps a contended port until its burst budget is spent.
  always_comb begin
    gnt = req;
    if (&req) begin
      case (owner_q)
        OWN0:    gnt = (burst_q < BURST_CAP) ? 2'b01 : 2'b10;
        OWN1:    gnt = (burst_q < BURST_CAP) ? 2'b10 : 2'b01;
        default: gnt = last_q ? 2'b01 : 2'b10;
      endcase
    end
  end
`else
  logic unused_owner;
  assign unused_owner = ^owner_q;

  always_comb begin
    gnt = req;
    if (req[0]) gnt[1] = 1'b0;
  end
`endif

endmodule

// File: rtl/lsu_arbiter.sv
// Shares the single LSU data port between the core (port 0) and a secondary master (port 1).
// Build macro LSU_ARB_RR_EN enables round-robin with MAX_BURST cap; default is fixed priority.
module lsu_arbiter
  import lsu_arb_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_0,
  input  logic              i_req_1,
  input  logic [DATA_W-1:0] i_addr_0,
  input  logic [DATA_W-1:0] i_addr_1,
  input  logic [DATA_W-1:0] i_wdata_0,
  input  logic [DATA_W-1:0] i_wdata_1,
  input  logic              i_wren_0,
  input  logic              i_wren_1,
  input  logic [2:0]        i_funct3_0,
  input  logic [2:0]        i_funct3_1,
  output logic              o_gnt_0,
  output logic              o_gnt_1,
  output logic              o_rvalid_0,
  output logic              o_rvalid_1,
  output logic [DATA_W-1:0] o_rdata_0,
  output logic [DATA_W-1:0] o_rdata_1,
  output logic [DATA_W-1:0] o_lsu_addr,
  output logic [DATA_W-1:0] o_lsu_wdata,
  output logic              o_lsu_wren,
  output logic [2:0]        o_lsu_funct3,
  input  logic [DATA_W-1:0] i_lsu_rdata,
  output logic              o_busy
);

  logic [LSU_ARB_NPORTS-1:0] req;
  logic [LSU_ARB_NPORTS-1:0] gnt;
  lsu_req_t                  port_req [LSU_ARB_NPORTS];
  lsu_req_t                  lsu;
  owner_e                    owner_q, owner_d;
  logic [LSU_ARB_NPORTS-1:0] rvalid_p1;
  logic [DATA_W-1:0]         rdata_p1 [LSU_ARB_NPORTS];

  // Gating requests with reset keeps grants and LSU outputs at zero while held in reset.
  assign req         = {i_req_1, i_req_0} & {LSU_ARB_NPORTS{i_rst}};
  assign port_req[0] = '{addr: i_addr_0, wdata: i_wdata_0, wren: i_wren_0, funct3: i_funct3_0};
  assign port_req[1] = '{addr: i_addr_1, wdata: i_wdata_1, wren: i_wren_1, funct3: i_funct3_1};

`ifdef LSU_ARB_RR_EN
  localparam int                 BURST_W   = $clog2(MAX_BURST + 1);
  localparam logic [BURST_W-1:0] BURST_CAP = BURST_W'(MAX_BURST);

  logic [BURST_W-1:0] burst_q, burst_d;
  logic               last_q, last_d;

  lsu_arb_pick #(
    .MAX_BURST (MAX_BURST),
    .BURST_W   (BURST_W)
  ) u_pick (
    .req     (req),
    .owner_q (owner_q),
    .burst_q (burst_q),
    .last_q  (last_q),
    .gnt     (gnt)
  );
`else
  logic unused_cfg;
  assign unused_cfg = ^MAX_BURST;

  lsu_arb_pick u_pick (
    .req     (req),
    .owner_q (owner_q),
    .gnt     (gnt)
  );
`endif

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      owner_q <= IDLE;
`ifdef LSU_ARB_RR_EN
      burst_q <= '0;
      last_q  <= 1'b1;
`endif
    end else begin
      owner_q <= owner_d;
`ifdef LSU_ARB_RR_EN
      burst_q <= burst_d;
      last_q  <= last_d;
`endif
    end
  end

  always_comb begin
    owner_d = IDLE;
    if (gnt[0])      owner_d = OWN0;
    else if (gnt[1]) owner_d = OWN1;
`ifdef LSU_ARB_RR_EN
    burst_d = '0;
    last_d  = last_q;
    if (|gnt) begin
      last_d = gnt[1];
      if (owner_d == owner_q)
        burst_d = (burst_q == BURST_CAP) ? burst_q : burst_q + BURST_W'(1);
      else
        burst_d = BURST_W'(1);
    end
`endif
  end

  always_comb begin
    lsu = '0;
    if (gnt[0])      lsu = port_req[0];
    else if (gnt[1]) lsu = port_req[1];
  end

  assign o_gnt_0      = gnt[0];
  assign o_gnt_1      = gnt[1];
  assign o_busy       = |gnt;
  assign o_lsu_addr   = lsu.addr;
  assign o_lsu_wdata  = lsu.wdata;
  assign o_lsu_wren   = lsu.wren;
  assign o_lsu_funct3 = lsu.funct3;

  // p0 -> p1: load data from the LSU is captured for the winning port
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      rvalid_p1 <= '0;
      for (int p = 0; p < LSU_ARB_NPORTS; p++) rdata_p1[p] <= '0;
    end else begin
      for (int p = 0; p < LSU_ARB_NPORTS; p++) begin
        rvalid_p1[p] <= gnt[p] & ~port_req[p].wren;
        if (gnt[p] && !port_req[p].wren) rdata_p1[p] <= i_lsu_rdata;
      end
    end
  end

  assign o_rvalid_0 = rvalid_p1[0];
  assign o_rvalid_1 = rvalid_p1[1];
  assign o_rdata_0  = rdata_p1[0];
  assign o_rdata_1  = rdata_p1[1];

endmodule

// File: tb/tb_lsu_arbiter.sv
// Scoreboard bench for lsu_arbiter with a small word-addressed LSU memory model.
// Expected grant pattern under contention follows the LSU_ARB_RR_EN build macro.
module tb_lsu_arbiter;
  import lsu_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_0, req_1;
  logic [31:0] addr_0, addr_1, wdata_0, wdata_1;
  logic        wren_0, wren_1;
  logic [2:0]  f3_0, f3_1;
  logic        gnt_0, gnt_1, rvalid_0, rvalid_1;
  logic [31:0] rdata_0, rdata_1;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic        lsu_wren, busy;
  logic [2:0]  lsu_f3;

  always #5 clk = ~clk;

  lsu_arbiter #(.MAX_BURST(4)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_0(req_0), .i_req_1(req_1),
    .i_addr_0(addr_0), .i_addr_1(addr_1),
    .i_wdata_0(wdata_0), .i_wdata_1(wdata_1),
    .i_wren_0(wren_0), .i_wren_1(wren_1),
    .i_funct3_0(f3_0), .i_funct3_1(f3_1),
    .o_gnt_0(gnt_0), .o_gnt_1(gnt_1),
    .o_rvalid_0(rvalid_0), .o_rvalid_1(rvalid_1),
    .o_rdata_0(rdata_0), .o_rdata_1(rdata_1),
    .o_lsu_addr(lsu_addr), .o_lsu_wdata(lsu_wdata),
    .o_lsu_wren(lsu_wren), .o_lsu_funct3(lsu_f3),
    .i_lsu_rdata(lsu_rdata), .o_busy(busy)
  );

  // LSU model: combinational read, write on the edge; preloaded while reset is held
  logic [31:0] mem [0:255];
  int          wr_cnt = 0;
  assign lsu_rdata = mem[lsu_addr[9:2]];

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[4]    <= 32'hBAD0_0010;
      mem[8]    <= 32'hA5A5_0020;
      mem[9]    <= 32'h5A5A_0024;
      mem[8'h40] <= 32'hDEAD_BEEF;
    end else if (lsu_wren) begin
      mem[lsu_addr[9:2]] <= lsu_wdata;
      wr_cnt <= wr_cnt + 1;
    end
  end

  typedef struct {
    logic        port;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wren;
    logic [2:0]  f3;
  } gnt_exp_t;

  typedef struct {
    logic        port;
    logic [31:0] data;
  } rv_exp_t;

  gnt_exp_t gq[$];
  rv_exp_t  rq[$];
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_acc(input logic port, input logic [31:0] a, input logic [31:0] wd,
                            input logic we, input logic [2:0] f3, input logic rv,
                            input logic [31:0] rd);
    gnt_exp_t g;
    rv_exp_t  r;
    g = '{port, a, wd, we, f3};
    gq.push_back(g);
    if (rv) begin
      r = '{port, rd};
      rq.push_back(r);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard queues
  always @(negedge clk) begin
    gnt_exp_t g;
    rv_exp_t  r;
    chk("gnt_onehot", {31'b0, gnt_0 & gnt_1}, 32'd0);
    chk("rvalid_onehot", {31'b0, rvalid_0 & rvalid_1}, 32'd0);
    if (gnt_0 || gnt_1) begin
      if (gq.size() == 0) begin
        chk("gnt_unexpected", {30'b0, gnt_1, gnt_0}, 32'd0);
      end else begin
        g = gq.pop_front();
        chk("gnt_port", {31'b0, gnt_1}, {31'b0, g.port});
        chk("lsu_addr", lsu_addr, g.addr);
        chk("lsu_wdata", lsu_wdata, g.wdata);
        chk("lsu_wren", {31'b0, lsu_wren}, {31'b0, g.wren});
        chk("lsu_funct3", {29'b0, lsu_f3}, {29'b0, g.f3});
        chk("busy", {31'b0, busy}, 32'd1);
      end
    end else begin
      chk("idle_wren", {31'b0, lsu_wren}, 32'd0);
      chk("idle_addr", lsu_addr, 32'd0);
      chk("idle_busy", {31'b0, busy}, 32'd0);
    end
    if (rvalid_0 || rvalid_1) begin
      if (rq.size() == 0) begin
        chk("rvalid_unexpected", {30'b0, rvalid_1, rvalid_0}, 32'd0);
      end else begin
        r = rq.pop_front();
        chk("rvalid_port", {31'b0, rvalid_1}, {31'b0, r.port});
        chk("rdata", rvalid_1 ? rdata_1 : rdata_0, r.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] pat;
    int          wr_base;
`ifdef LSU_ARB_RR_EN
    pat = 12'h0F0;
`else
    pat = 12'h000;
`endif
    rst   = 1'b0;
    req_0 = 1'b1; addr_0 = 32'h20; wdata_0 = 32'h0;         wren_0 = 1'b0; f3_0 = 3'b010;
    req_1 = 1'b1; addr_1 = 32'h24; wdata_1 = 32'hFFFF_0000; wren_1 = 1'b0; f3_1 = 3'b100;

    repeat (3) begin
      @(negedge clk);
      chk("rst_gnt0", {31'b0, gnt_0}, 32'd0);
      chk("rst_gnt1", {31'b0, gnt_1}, 32'd0);
      chk("rst_wren", {31'b0, lsu_wren}, 32'd0);
      chk("rst_rvalid", {30'b0, rvalid_1, rvalid_0}, 32'd0);
      chk("rst_rdata0", rdata_0, 32'd0);
    end

    // Release reset with both requests held: contention pattern starting with port 0
    cyc();
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (pat[i]) expect_acc(1'b1, 32'h24, 32'hFFFF_0000, 1'b0, 3'b100, 1'b1, 32'h5A5A_0024);
      else        expect_acc(1'b0, 32'h20, 32'h0,         1'b0, 3'b010, 1'b1, 32'hA5A5_0020);
      cyc();
    end
    req_0 = 1'b0; req_1 = 1'b0;
    cyc();

    // Single master on port 1
    req_1 = 1'b1; addr_1 = 32'h100; f3_1 = 3'b010;
    expect_acc(1'b1, 32'h100, 32'hFFFF_0000, 1'b0, 3'b010, 1'b1, 32'hDEAD_BEEF);
    cyc();
    req_1 = 1'b0;
    cyc();
    @(negedge clk);
    chk("rdata1_hold", rdata_1, 32'hDEAD_BEEF);
    chk("rdata0_hold", rdata_0, 32'hA5A5_0020);
    cyc();

    // Store isolation: port 0 stores while port 1 waits, then port 1 reads it back
    wr_base = wr_cnt;
    req_0 = 1'b1; addr_0 = 32'h10; wdata_0 = 32'h1234_5678; wren_0 = 1'b1; f3_0 = 3'b010;
    req_1 = 1'b1; addr_1 = 32'h10; wren_1 = 1'b0; f3_1 = 3'b010;
    expect_acc(1'b0, 32'h10, 32'h1234_5678, 1'b1, 3'b010, 1'b0, 32'h0);
    cyc();
    req_0 = 1'b0;
    expect_acc(1'b1, 32'h10, 32'hFFFF_0000, 1'b0, 3'b010, 1'b1, 32'h1234_5678);
    cyc();
    req_1 = 1'b0;
    cyc();
    cyc();
    chk("store_pulses", 32'(wr_cnt - wr_base), 32'd1);

    // Reset asserted the cycle after a granted load drops its rvalid
    req_0 = 1'b1; addr_0 = 32'h24; wren_0 = 1'b0; f3_0 = 3'b000;
    expect_acc(1'b0, 32'h24, 32'h1234_5678, 1'b0, 3'b000, 1'b0, 32'h0);
    cyc();
    rst = 1'b0; req_0 = 1'b0;
    @(negedge clk);
    chk("midrst_rvalid0", {31'b0, rvalid_0}, 32'd0);
    chk("midrst_rdata0", rdata_0, 32'd0);
    chk("midrst_owner", 32'(dut.owner_q), 32'(IDLE));
`ifdef LSU_ARB_RR_EN
    chk("midrst_burst", 32'(dut.burst_q), 32'd0);
`endif
    cyc();
    rst = 1'b1;
    req_0 = 1'b1; addr_0 = 32'h20; f3_0 = 3'b010;
    expect_acc(1'b0, 32'h20, 32'h1234_5678, 1'b0, 3'b010, 1'b1, 32'hA5A5_0020);
    cyc();
    req_0 = 1'b0;
    cyc();
    cyc();

    chk("gnt_queue_drained", 32'(gq.size()), 32'd0);
    chk("rvalid_queue_drained", 32'(rq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
